// File: rtl/shift_pkg.sv
// Shared types and constants for the sequential 32-bit right shifter.
package shift_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;
  localparam int STAGE_W = 3;

  localparam logic [STAGE_W-1:0] LAST_STAGE = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_right_stage.sv
// One power-of-two right-shift stage: shifts by 2^stage_i with fill_i when en_i is set.
module shift_right_stage
  import shift_pkg::*;
(
  input  logic [XLEN-1:0]    data_i,
  input  logic               fill_i,
  input  logic [STAGE_W-1:0] stage_i,
  input  logic               en_i,
  output logic [XLEN-1:0]    data_o
);

  // Select the shift distance for the current stage
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (stage_i)
        3'd0:    data_o = {{1{fill_i}},  data_i[XLEN-1:1]};
        3'd1:    data_o = {{2{fill_i}},  data_i[XLEN-1:2]};
        3'd2:    data_o = {{4{fill_i}},  data_i[XLEN-1:4]};
        3'd3:    data_o = {{8{fill_i}},  data_i[XLEN-1:8]};
        3'd4:    data_o = {{16{fill_i}}, data_i[XLEN-1:16]};
        default: data_o = data_i;
      endcase
    end else begin
      data_o = data_i;
    end
  end

endmodule

// File: rtl/shifter_right_seq_32b.sv
// Multi-cycle logarithmic right shifter (SRL/SRA), one stage per clock, valid/ready on both sides.
// Optional macro SHIFT_RIGHT_EARLY_EXIT_EN: leave SHIFT once no higher amount bits remain.
module shifter_right_seq_32b
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in,
  input  logic [4:0]  cntrl,
  input  logic        arith,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
);

  state_e               state_q, state_d;
  logic [XLEN-1:0]      data_q, data_d;
  logic [SHAMT_W-1:0]   amt_q, amt_d;
  logic                 fill_q, fill_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;

  logic [SHAMT_W-1:0]   rest_s;
  logic [XLEN-1:0]      stage_out_s;
  logic                 last_s;

  // rest_s[0] is the amount bit for the current stage; upper bits are still pending
  assign rest_s = amt_q >> stage_q;

  shift_right_stage u_stage (
    .data_i  (data_q),
    .fill_i  (fill_q),
    .stage_i (stage_q),
    .en_i    (rest_s[0]),
    .data_o  (stage_out_s)
  );

`ifdef SHIFT_RIGHT_EARLY_EXIT_EN
  assign last_s = (stage_q == LAST_STAGE) || (rest_s[SHAMT_W-1:1] == 4'd0);
`else
  assign last_s = (stage_q == LAST_STAGE);
`endif

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    fill_d  = fill_q;
    stage_d = stage_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in;
          amt_d   = cntrl;
          fill_d  = arith & in[31];
          stage_d = 3'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        data_d  = stage_out_s;
        stage_d = stage_q + 3'd1;
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      data_q  <= 32'd0;
      amt_q   <= 5'd0;
      fill_q  <= 1'b0;
      stage_q <= 3'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      fill_q  <= fill_d;
      stage_q <= stage_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = data_q;

endmodule

// File: tb/tb_shifter_right_seq_32b.sv
// Directed self-checking bench for shifter_right_seq_32b.
module tb_shifter_right_seq_32b;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_d;
  logic [4:0]  cntrl;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_d;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  shifter_right_seq_32b dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_d),
    .cntrl     (cntrl),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_d)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int exp_lat(input logic [4:0] a);
`ifdef SHIFT_RIGHT_EARLY_EXIT_EN
    int m = 0;
    for (int i = 0; i < 5; i++) if (a[i]) m = i + 1;
    return (m < 1) ? 1 : m;
`else
    return 5;
`endif
  endfunction

  task automatic accept(input string tag, input logic [31:0] v, input logic [4:0] c, input logic a);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_eq({tag, "_ready_before"}, {31'd0, in_ready}, 32'd1);
    in_d = v; cntrl = c; arith = a; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, "_busy_after_accept"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] v, input logic [4:0] c,
                        input logic a, input logic [31:0] exp);
    int lat;
    accept(tag, v, c, a);
    wait_done(lat);
    check_eq({tag, "_latency"}, lat, exp_lat(c));
    check_eq({tag, "_out"}, out_d, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    check_eq({tag, "_out_kept"}, out_d, exp);
  endtask

  initial begin
    int lat;
    rstn = 1'b0; in_valid = 1'b0; in_d = 32'd0; cntrl = 5'd0; arith = 1'b0; out_ready = 1'b0;
    #2;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out", out_d, 32'd0);
    #10 rstn = 1'b1;
    @(posedge clk); #1;

    run_op("srl31",     32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
    run_op("sra31",     32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
    run_op("sra8_pos",  32'h1234_5678, 5'd8,  1'b1, 32'h0012_3456);
    run_op("zero",      32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF);
    run_op("srl5",      32'hF000_0000, 5'd5,  1'b0, 32'h0780_0000);
    run_op("sra5",      32'hF000_0000, 5'd5,  1'b1, 32'hFF80_0000);
    run_op("sra1",      32'h8000_0001, 5'd1,  1'b1, 32'hC000_0000);
    run_op("sra31_pos", 32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000);
    run_op("srl16",     32'hA5A5_A5A5, 5'd16, 1'b0, 32'h0000_A5A5);

    // Backpressure: DONE held, input pulses ignored
    accept("bp", 32'hA5A5_A5A5, 5'd16, 1'b1);
    wait_done(lat);
    check_eq("bp_out", out_d, 32'hFFFF_A5A5);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; in_d = 32'h0000_0001; cntrl = 5'd1; arith = 1'b0;
      @(posedge clk); #1;
      check_eq("bp_hold_out", out_d, 32'hFFFF_A5A5);
      check_eq("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check_eq("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    check_eq("bp_idle_out", out_d, 32'hFFFF_A5A5);

    // Reset during stage 2 aborts the operation
    accept("rst_mid", 32'h1234_5678, 5'd31, 1'b0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check_eq("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_mid_out", out_d, 32'd0);
    #4 rstn = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_mid_out_after", out_d, 32'd0);
    run_op("post_rst", 32'hF0F0_0000, 5'd4, 1'b1, 32'hFF0F_0000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
